// File: rtl/processor_pkg.sv
// Shared processor constants for the OUT path (word width, OUT FIFO sizing).
package processor_pkg;

   localparam int unsigned WORD_W         = 16;
   localparam int unsigned OUT_FIFO_DEPTH = 8;
   localparam int unsigned OUT_SLACK      = 3;

   // Occupancy at which issue of further OUT instructions must be frozen.
   function automatic int unsigned stall_threshold(input int unsigned depth,
                                                   input int unsigned slack);
      return depth - slack;
   endfunction

endpackage

// File: rtl/out_port_fifo.sv
// Circular FIFO for the OUT port: pointers, storage, occupancy count, full/empty.
// Callers must only assert push_i when a slot is free (or a pop happens the same cycle).
module out_port_fifo #(
   parameter int unsigned DW    = 16,
   parameter int unsigned DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [DW-1:0]            wdata_i,
   output logic [DW-1:0]            rdata_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     full_o,
   output logic                     empty_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [DW-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push_i && !pop_i)
         count_d = count_q + 1'b1;
      else if (pop_i && !push_i)
         count_d = count_q - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is not reset; the pointers alone define which entries are live.
   always_ff @(posedge clk) begin
      if (reset && push_i) mem_q[wr_ptr_q] <= wdata_i;
   end

   assign rdata_o = mem_q[rd_ptr_q];
   assign count_o = count_q;
   assign full_o  = (count_q == FULL_CNT);
   assign empty_o = (count_q == '0);

endmodule

// File: rtl/out_port_unit.sv
// OUT port unit: buffers committed OUT words for a valid/ready device, raises an
// early stall to the HDU, flags dropped words, and keeps the legacy last_out value.
// Optional OUT_PORT_PARITY_EN adds port_parity (even parity stored per entry).
module out_port_unit
#(
   parameter int unsigned WORD_W = processor_pkg::WORD_W,
   parameter int unsigned DEPTH  = processor_pkg::OUT_FIFO_DEPTH,
   parameter int unsigned SLACK  = processor_pkg::OUT_SLACK
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wb_out_en,
   input  logic [WORD_W-1:0]        wb_out_data,
   output logic                     port_valid,
   output logic [WORD_W-1:0]        port_data,
   input  logic                     port_ready,
   output logic [WORD_W-1:0]        last_out,
   output logic                     stall_req,
`ifdef OUT_PORT_PARITY_EN
   output logic                     port_parity,
`endif
   output logic                     overflow,
   output logic [$clog2(DEPTH):0]   count
);

   import processor_pkg::*;

   localparam int unsigned CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] STALL_AT = CW'(stall_threshold(DEPTH, SLACK));
`ifdef OUT_PORT_PARITY_EN
   localparam int unsigned FW = WORD_W + 1;
`else
   localparam int unsigned FW = WORD_W;
`endif

   logic [FW-1:0]     fifo_wdata;
   logic [FW-1:0]     fifo_rdata;
   logic [CW-1:0]     fifo_count;
   logic              fifo_full;
   logic              fifo_empty;
   logic              pop;
   logic              push_ok;
   logic              drop;
   logic [WORD_W-1:0] last_out_q, last_out_d;
   logic              overflow_q, overflow_d;

   // A pop frees the head slot on the same edge, so a full FIFO still accepts a push then.
   assign pop     = !fifo_empty && port_ready;
   assign push_ok = wb_out_en && (!fifo_full || pop);
   assign drop    = wb_out_en && fifo_full && !pop;

`ifdef OUT_PORT_PARITY_EN
   assign fifo_wdata  = {^wb_out_data, wb_out_data};
   assign port_parity = fifo_empty ? 1'b0 : fifo_rdata[WORD_W];
`else
   assign fifo_wdata  = wb_out_data;
`endif

   out_port_fifo #(
      .DW    (FW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (push_ok),
      .pop_i   (pop),
      .wdata_i (fifo_wdata),
      .rdata_o (fifo_rdata),
      .count_o (fifo_count),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   always_comb begin
      last_out_d = last_out_q;
      overflow_d = overflow_q;
      if (push_ok) last_out_d = wb_out_data;
      if (drop)    overflow_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         last_out_q <= '0;
         overflow_q <= 1'b0;
      end else begin
         last_out_q <= last_out_d;
         overflow_q <= overflow_d;
      end
   end

   assign port_valid = !fifo_empty;
   assign port_data  = fifo_rdata[WORD_W-1:0];
   assign count      = fifo_count;
   assign stall_req  = (fifo_count >= STALL_AT);
   assign last_out   = last_out_q;
   assign overflow   = overflow_q;

endmodule

// File: tb/tb_out_port_unit.sv
// Self-checking bench for out_port_unit: queue-based reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_out_port_unit;

   localparam int unsigned W = 16;
   localparam int unsigned D = 8;
   localparam int unsigned S = 3;

   logic                  clk = 1'b0;
   logic                  reset;
   logic                  wb_out_en;
   logic [W-1:0]          wb_out_data;
   logic                  port_ready;
   logic                  port_valid;
   logic [W-1:0]          port_data;
   logic [W-1:0]          last_out;
   logic                  stall_req;
   logic                  overflow;
   logic [$clog2(D):0]    count;
`ifdef OUT_PORT_PARITY_EN
   logic                  port_parity;
`endif

   always #5 clk = ~clk;

   out_port_unit #(.WORD_W(W), .DEPTH(D), .SLACK(S)) dut (
      .clk         (clk),
      .reset       (reset),
      .wb_out_en   (wb_out_en),
      .wb_out_data (wb_out_data),
      .port_valid  (port_valid),
      .port_data   (port_data),
      .port_ready  (port_ready),
      .last_out    (last_out),
      .stall_req   (stall_req),
`ifdef OUT_PORT_PARITY_EN
      .port_parity (port_parity),
`endif
      .overflow    (overflow),
      .count       (count)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: the buffer is simply an ordered list of accepted words.
   logic [W-1:0] mq [$];
   logic [W-1:0] m_last = '0;
   logic         m_ovf = 1'b0;
   bit           model_live = 1'b0;

   always @(posedge clk) begin
      bit m_pop, m_full;
      if (!reset) begin
         mq.delete();
         m_last     = '0;
         m_ovf      = 1'b0;
         model_live = 1'b1;
      end else if (model_live) begin
         m_pop  = (mq.size() != 0) && port_ready;
         m_full = (mq.size() == D);
         if (wb_out_en && m_full && !m_pop) m_ovf = 1'b1;
         if (m_pop) void'(mq.pop_front());
         if (wb_out_en && (!m_full || m_pop)) begin
            mq.push_back(wb_out_data);
            m_last = wb_out_data;
         end
      end
   end

   always @(negedge clk) begin
      if (model_live) begin
         chk("count", count, mq.size());
         chk("port_valid", port_valid, mq.size() != 0);
         chk("stall_req", stall_req, mq.size() >= D - S);
         chk("overflow", overflow, m_ovf);
         chk("last_out", last_out, m_last);
         if (mq.size() != 0) chk("port_data", port_data, mq[0]);
`ifdef OUT_PORT_PARITY_EN
         chk("port_parity", port_parity, (mq.size() != 0) ? ^mq[0] : 1'b0);
`endif
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   int en_pct;
   int rdy_pct;

   initial begin
      reset       = 1'b0;
      wb_out_en   = 1'b0;
      wb_out_data = '0;
      port_ready  = 1'b0;
      step();
      step();
      chk("rst_count", count, 0);
      chk("rst_valid", port_valid, 0);
      chk("rst_last", last_out, 0);
      chk("rst_ovf", overflow, 0);
      reset = 1'b1;

      // single word, held while device is not ready
      wb_out_en = 1'b1; wb_out_data = 16'h00A5;
      step();
      wb_out_en = 1'b0;
      chk("t1_valid", port_valid, 1);
      chk("t1_data", port_data, 16'h00A5);
      chk("t1_last", last_out, 16'h00A5);
      chk("t1_count", count, 1);
      for (int i = 0; i < 5; i++) begin
         step();
         chk("t1_hold", port_data, 16'h00A5);
      end
      port_ready = 1'b1;
      step();
      port_ready = 1'b0;
      chk("t1_empty", port_valid, 0);

      // stall threshold at occupancy 5
      for (int i = 1; i <= 5; i++) begin
         wb_out_en = 1'b1; wb_out_data = W'(i);
         step();
         chk("t2_count", count, i);
         chk("t2_stall", stall_req, (i >= 5) ? 1 : 0);
      end
      wb_out_en = 1'b0; port_ready = 1'b1;
      step();
      port_ready = 1'b0;
      chk("t2_stall_fall", stall_req, 0);
      chk("t2_count4", count, 4);
      port_ready = 1'b1;
      repeat (4) step();
      port_ready = 1'b0;
      chk("t2_drained", count, 0);

      // overflow: ninth word dropped
      for (int i = 0; i < 8; i++) begin
         wb_out_en = 1'b1; wb_out_data = W'(16'h0100 + i);
         step();
      end
      chk("t3_full", count, 8);
      wb_out_data = 16'hDEAD;
      step();
      wb_out_en = 1'b0;
      chk("t3_ovf", overflow, 1);
      chk("t3_count", count, 8);
      chk("t3_last", last_out, 16'h0107);
      port_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         chk("t3_order", port_data, 16'h0100 + i);
         step();
      end
      port_ready = 1'b0;
      chk("t3_empty", port_valid, 0);
      chk("t3_sticky", overflow, 1);

      reset = 1'b0;
      step();
      reset = 1'b1;
      chk("t3_rst_ovf", overflow, 0);

      // full + simultaneous push and pop
      for (int i = 0; i < 8; i++) begin
         wb_out_en = 1'b1; wb_out_data = W'(16'h0200 + i);
         step();
      end
      wb_out_data = 16'h02FF; port_ready = 1'b1;
      step();
      wb_out_en = 1'b0; port_ready = 1'b0;
      chk("t4_count", count, 8);
      chk("t4_ovf", overflow, 0);
      chk("t4_head", port_data, 16'h0201);
      chk("t4_last", last_out, 16'h02FF);
      port_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         chk("t4_order", port_data, (i < 7) ? (16'h0201 + i) : 16'h02FF);
         step();
      end
      port_ready = 1'b0;

      // streaming with ready held high
      port_ready = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         wb_out_en = 1'b1; wb_out_data = W'(i);
         step();
         chk("t5_data", port_data, i);
         chk("t5_count", count, 1);
      end
      wb_out_en = 1'b0;
      step();
      port_ready = 1'b0;
      chk("t5_empty", count, 0);

      // reset during an active pop and push
      for (int i = 0; i < 3; i++) begin
         wb_out_en = 1'b1; wb_out_data = W'(16'h0031 + i);
         step();
      end
      port_ready = 1'b1; reset = 1'b0; wb_out_data = 16'h03FF;
      step();
      reset = 1'b1; wb_out_en = 1'b0; port_ready = 1'b0;
      chk("t6_count", count, 0);
      chk("t6_valid", port_valid, 0);
      chk("t6_ovf", overflow, 0);
      chk("t6_last", last_out, 0);

`ifdef OUT_PORT_PARITY_EN
      chk("par_empty", port_parity, 0);
      wb_out_en = 1'b1; wb_out_data = 16'h0007;
      step();
      wb_out_data = 16'h0003;
      step();
      wb_out_en = 1'b0;
      chk("par_0007", port_parity, 1);
      port_ready = 1'b1;
      step();
      chk("par_0003", port_parity, 0);
      step();
      port_ready = 1'b0;
      chk("par_empty2", port_parity, 0);
`endif

      // randomized traffic with occasional resets
      en_pct = 50; rdy_pct = 50;
      for (int c = 0; c < 3000; c++) begin
         if (c % 300 == 0) begin
            en_pct  = $urandom_range(10, 95);
            rdy_pct = $urandom_range(5, 95);
         end
         reset       = ($urandom_range(0, 199) != 0);
         wb_out_en   = ($urandom_range(0, 99) < en_pct);
         port_ready  = ($urandom_range(0, 99) < rdy_pct);
         wb_out_data = W'($urandom);
         step();
      end
      reset = 1'b1; wb_out_en = 1'b0; port_ready = 1'b0;
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
